// File: rtl/display7_pkg.sv
// Shared constants and types for the 7-segment capture path.
package display7_pkg;

    // Lit segment patterns, bit order g..a (bit 0 = a).
    localparam logic [6:0] PAT_0     = 7'h3F;
    localparam logic [6:0] PAT_1     = 7'h06;
    localparam logic [6:0] PAT_2     = 7'h5B;
    localparam logic [6:0] PAT_3     = 7'h4F;
    localparam logic [6:0] PAT_4     = 7'h66;
    localparam logic [6:0] PAT_5     = 7'h6D;
    localparam logic [6:0] PAT_6     = 7'h7D;
    localparam logic [6:0] PAT_7     = 7'h07;
    localparam logic [6:0] PAT_8     = 7'h7F;
    localparam logic [6:0] PAT_9     = 7'h6F;
    localparam logic [6:0] PAT_E     = 7'h79;
    localparam logic [6:0] PAT_R     = 7'h50;
    localparam logic [6:0] PAT_O     = 7'h5C;
    localparam logic [6:0] PAT_BLANK = 7'h00;

    localparam logic [3:0] CODE_E     = 4'hA;
    localparam logic [3:0] CODE_R     = 4'hB;
    localparam logic [3:0] CODE_O     = 4'hC;
    localparam logic [3:0] CODE_BAD   = 4'hE;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    localparam logic [15:0] FRAME_ERRO = {CODE_E, CODE_R, CODE_R, CODE_O};

    localparam logic [1:0] IDX_D1 = 2'd3;
    localparam logic [1:0] IDX_D2 = 2'd2;
    localparam logic [1:0] IDX_D3 = 2'd1;
    localparam logic [1:0] IDX_D4 = 2'd0;

    typedef enum logic [1:0] {HUNT, SETTLE, HELD} cap_state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } sel_t;

    // en_b = {D1, D2, D3, D4}, active-low; only a single low enable is a real digit.
    function automatic sel_t decode_select(input logic [3:0] en_b);
        sel_t s;
        s.valid = 1'b1;
        s.idx   = IDX_D4;
        case (en_b)
            4'b0111: s.idx = IDX_D1;
            4'b1011: s.idx = IDX_D2;
            4'b1101: s.idx = IDX_D3;
            4'b1110: s.idx = IDX_D4;
            default: s.valid = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Inverse of the forward segment decoder: lit pattern to digit code.
module seg7_pattern_decode
    import display7_pkg::*;
(
    input  logic [6:0] lit,
    output logic [3:0] code,
    output logic       bad
);

    // Table lookup; anything the forward decoder never emits is flagged.
    always_comb begin
        code = CODE_BAD;
        bad  = 1'b0;
        case (lit)
            PAT_0:     code = 4'h0;
            PAT_1:     code = 4'h1;
            PAT_2:     code = 4'h2;
            PAT_3:     code = 4'h3;
            PAT_4:     code = 4'h4;
            PAT_5:     code = 4'h5;
            PAT_6:     code = 4'h6;
            PAT_7:     code = 4'h7;
            PAT_8:     code = 4'h8;
            PAT_9:     code = 4'h9;
            PAT_E:     code = CODE_E;
            PAT_R:     code = CODE_R;
            PAT_O:     code = CODE_O;
            PAT_BLANK: code = CODE_BLANK;
            default: begin
                code = CODE_BAD;
                bad  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/display7_capture.sv
// Captures a multiplexed 4-digit 7-segment scan back into digit codes.
//
// state  | meaning
// HUNT   | no valid select seen since the last blanking gap
// SETTLE | sample latched, counting identical cycles toward capture
// HELD   | current sample already captured, waiting for a change
module display7_capture
    import display7_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int STALL_CYC  = 1024
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [6:0]  SEGs,
    input  logic        SEG_P,
    input  logic        SEG_D1,
    input  logic        SEG_D2,
    input  logic        SEG_D3,
    input  logic        SEG_D4,
    output logic [15:0] Digits,
    output logic [3:0]  DotMask,
    output logic        Frame,
    output logic        Valid,
    output logic        BadPat,
    output logic        ErrMode,
    output logic        Stall
);

    localparam int CW = $clog2(SETTLE_CYC + 1);
    localparam int SW = $clog2(STALL_CYC + 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC);
    localparam logic [SW-1:0] STALL_LOAD  = SW'(STALL_CYC - 1);

    sel_t          sel;
    cap_state_t    state, state_nxt;
    logic [1:0]    lat_idx, lat_idx_nxt;
    logic [6:0]    lat_seg, lat_seg_nxt;
    logic          lat_dp, lat_dp_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          same;
    logic          capture;
    logic [3:0]    code;
    logic          bad;
    logic [3:0]    seen, seen_nxt;
    logic [15:0]   digits_nxt;
    logic [3:0]    dot_nxt;
    logic          frame_done;
    logic          have_idx;
    logic [1:0]    stall_idx;
    logic [SW-1:0] stall_rem, stall_rem_nxt;

    assign sel  = decode_select({SEG_D1, SEG_D2, SEG_D3, SEG_D4});
    assign same = (sel.idx == lat_idx) && (SEGs == lat_seg) && (SEG_P == lat_dp);

    seg7_pattern_decode u_decode (
        .lit  (~SEGs),
        .code (code),
        .bad  (bad)
    );

    // Settle FSM: next state, sample latch and capture strobe.
    always_comb begin
        state_nxt   = state;
        lat_idx_nxt = lat_idx;
        lat_seg_nxt = lat_seg;
        lat_dp_nxt  = lat_dp;
        cnt_nxt     = cnt;
        capture     = 1'b0;
        if (!sel.valid) begin
            state_nxt = HUNT;
            cnt_nxt   = '0;
        end else if (state == SETTLE && same) begin
            cnt_nxt = cnt + CNT_ONE;
            if (cnt + CNT_ONE == SETTLE_LAST) begin
                capture   = 1'b1;
                state_nxt = HELD;
            end
        end else if (state == HELD && same) begin
            state_nxt = HELD;
        end else begin
            // Fresh sample: first select after a gap, or any change.
            lat_idx_nxt = sel.idx;
            lat_seg_nxt = SEGs;
            lat_dp_nxt  = SEG_P;
            cnt_nxt     = CNT_ONE;
            if (SETTLE_CYC == 1) begin
                capture   = 1'b1;
                state_nxt = HELD;
            end else begin
                state_nxt = SETTLE;
            end
        end
    end

    // Digit/point update and frame completion, including the capturing edge.
    always_comb begin
        digits_nxt = Digits;
        dot_nxt    = DotMask;
        seen_nxt   = seen;
        if (capture) begin
            digits_nxt[{sel.idx, 2'b00} +: 4] = code;
            dot_nxt[sel.idx]                  = ~SEG_P;
            seen_nxt[sel.idx]                 = 1'b1;
        end
        frame_done = &seen_nxt;
    end

    // Stall timer: reloads on a new digit, counts down on repeats, holds in gaps.
    always_comb begin
        stall_rem_nxt = stall_rem;
        if (sel.valid) begin
            if (!have_idx || sel.idx != stall_idx) begin
                stall_rem_nxt = STALL_LOAD;
            end else if (stall_rem != '0) begin
                stall_rem_nxt = stall_rem - 1'b1;
            end
        end
    end

    // All state registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state     <= HUNT;
            lat_idx   <= '0;
            lat_seg   <= '0;
            lat_dp    <= 1'b0;
            cnt       <= '0;
            seen      <= '0;
            Digits    <= 16'hFFFF;
            DotMask   <= '0;
            Frame     <= 1'b0;
            Valid     <= 1'b0;
            BadPat    <= 1'b0;
            ErrMode   <= 1'b0;
            Stall     <= 1'b0;
            have_idx  <= 1'b0;
            stall_idx <= '0;
            stall_rem <= STALL_LOAD;
        end else begin
            state     <= state_nxt;
            lat_idx   <= lat_idx_nxt;
            lat_seg   <= lat_seg_nxt;
            lat_dp    <= lat_dp_nxt;
            cnt       <= cnt_nxt;
            Digits    <= digits_nxt;
            DotMask   <= dot_nxt;
            BadPat    <= capture & bad;
            Frame     <= frame_done;
            seen      <= frame_done ? 4'b0000 : seen_nxt;
            if (frame_done) begin
                Valid   <= 1'b1;
                ErrMode <= (digits_nxt == FRAME_ERRO);
            end
            have_idx  <= have_idx | sel.valid;
            if (sel.valid) begin
                stall_idx <= sel.idx;
            end
            stall_rem <= stall_rem_nxt;
            Stall     <= (have_idx | sel.valid) && (stall_rem_nxt == '0);
        end
    end

endmodule

// File: tb/tb_display7_capture.sv
// Self-checking bench for display7_capture against a run-length reference model.
module tb_display7_capture;

    localparam int SETTLE = 4;
    localparam int STALL  = 1024;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [6:0]  segs;
    logic        seg_p;
    logic        d1, d2, d3, d4;
    logic [15:0] digits;
    logic [3:0]  dot_mask;
    logic        frame, valid, bad_pat, err_mode, stall;

    int checks = 0;
    int errors = 0;
    int frames_seen = 0;
    int bads_seen = 0;

    // Reference model state
    logic [15:0] m_digits;
    logic [3:0]  m_dots, m_seen;
    logic        m_frame, m_valid, m_bad, m_err, m_stall;
    int          run, srun;
    logic [1:0]  p_idx, s_idx;
    logic [6:0]  p_seg;
    logic        p_dp, have;

    display7_capture #(.SETTLE_CYC(SETTLE), .STALL_CYC(STALL)) dut (
        .Clk     (clk),
        .Rst     (rst_b),
        .SEGs    (segs),
        .SEG_P   (seg_p),
        .SEG_D1  (d1),
        .SEG_D2  (d2),
        .SEG_D3  (d3),
        .SEG_D4  (d4),
        .Digits  (digits),
        .DotMask (dot_mask),
        .Frame   (frame),
        .Valid   (valid),
        .BadPat  (bad_pat),
        .ErrMode (err_mode),
        .Stall   (stall)
    );

    always #5 clk = ~clk;

    // Returns {bad, code} for a lit pattern.
    function automatic logic [4:0] ref_decode(input logic [6:0] lit);
        logic [6:0] pats [14];
        logic [3:0] codes [14];
        pats  = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
                  7'h79, 7'h50, 7'h5C, 7'h00};
        codes = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9,
                  4'hA, 4'hB, 4'hC, 4'hF};
        for (int i = 0; i < 14; i++)
            if (pats[i] == lit) return {1'b0, codes[i]};
        return {1'b1, 4'hE};
    endfunction

    task automatic model_edge();
        int   n_low;
        int   idx;
        logic [4:0] dec;
        n_low = 0;
        idx = 0;
        if (!d1) begin n_low++; idx = 3; end
        if (!d2) begin n_low++; idx = 2; end
        if (!d3) begin n_low++; idx = 1; end
        if (!d4) begin n_low++; idx = 0; end
        m_frame = 1'b0;
        m_bad   = 1'b0;
        if (!rst_b) begin
            m_digits = 16'hFFFF; m_dots = '0; m_seen = '0;
            m_valid = 1'b0; m_err = 1'b0; m_stall = 1'b0;
            run = 0; srun = 0; have = 1'b0;
        end else begin
            if (n_low != 1) begin
                run = 0;
            end else if (run > 0 && p_idx == 2'(idx) && p_seg == segs && p_dp == seg_p) begin
                run++;
            end else begin
                run = 1; p_idx = 2'(idx); p_seg = segs; p_dp = seg_p;
            end
            if (n_low == 1 && run == SETTLE) begin
                dec = ref_decode(~segs);
                m_bad = dec[4];
                m_digits[idx*4 +: 4] = dec[3:0];
                m_dots[idx] = ~seg_p;
                m_seen[idx] = 1'b1;
            end
            if (m_seen == 4'hF) begin
                m_frame = 1'b1; m_valid = 1'b1;
                m_err = (m_digits == 16'hABBC);
                m_seen = '0;
            end
            if (n_low == 1) begin
                if (!have || s_idx != 2'(idx)) srun = 1;
                else if (srun < STALL) srun++;
                have = 1'b1;
                s_idx = 2'(idx);
            end
            m_stall = have && (srun >= STALL);
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        frames_seen += int'(frame);
        bads_seen   += int'(bad_pat);
        check("digits",   digits,           m_digits);
        check("dotmask",  16'(dot_mask),    16'(m_dots));
        check("frame",    16'(frame),       16'(m_frame));
        check("valid",    16'(valid),       16'(m_valid));
        check("badpat",   16'(bad_pat),     16'(m_bad));
        check("errmode",  16'(err_mode),    16'(m_err));
        check("stall",    16'(stall),       16'(m_stall));
    endtask

    // dig: 0 none, 1..4 single digit, 5 = D1 and D2 together
    task automatic drive(input int dig, input logic [6:0] lit, input logic dp_lit);
        segs  = ~lit;
        seg_p = ~dp_lit;
        d1 = !(dig == 1 || dig == 5);
        d2 = !(dig == 2 || dig == 5);
        d3 = !(dig == 3);
        d4 = !(dig == 4);
    endtask

    task automatic show(input int dig, input logic [6:0] lit, input logic dp_lit, input int hold);
        drive(dig, lit, dp_lit);
        repeat (hold) tick();
    endtask

    task automatic scan(input logic [6:0] l1, l2, l3, l4, input int hold);
        show(1, l1, 1'b0, hold); show(0, 7'h00, 1'b0, 1);
        show(2, l2, 1'b0, hold); show(0, 7'h00, 1'b0, 1);
        show(3, l3, 1'b0, hold); show(0, 7'h00, 1'b0, 1);
        show(4, l4, 1'b0, hold); show(0, 7'h00, 1'b0, 1);
    endtask

    initial begin
        logic [6:0] rpats [14];
        rpats = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
                  7'h79, 7'h50, 7'h5C, 7'h00};
        p_idx = '0; s_idx = '0; p_seg = '0; p_dp = 1'b0;

        // Reset
        rst_b = 1'b0;
        drive(0, 7'h00, 1'b0);
        tick(); tick();
        check("rst_digits", digits, 16'hFFFF);
        check("rst_valid", 16'(valid), 16'h0);
        rst_b = 1'b1;

        // "1234"
        frames_seen = 0;
        scan(7'h06, 7'h5B, 7'h4F, 7'h66, 8);
        check("frames_1234", 16'(frames_seen), 16'd1);
        check("digits_1234", digits, 16'h1234);
        check("dots_1234", 16'(dot_mask), 16'h0);
        check("valid_1234", 16'(valid), 16'h1);
        check("err_1234", 16'(err_mode), 16'h0);

        // "Erro" then "0000"
        scan(7'h79, 7'h50, 7'h50, 7'h5C, 8);
        check("digits_erro", digits, 16'hABBC);
        check("err_erro", 16'(err_mode), 16'h1);
        scan(7'h3F, 7'h3F, 7'h3F, 7'h3F, 8);
        check("err_0000", 16'(err_mode), 16'h0);

        // Short-lived D2 pattern is never captured
        show(2, 7'h06, 1'b0, 3);
        show(2, 7'h6D, 1'b0, 3);
        check("d2_before", 16'(digits[11:8]), 16'h0);
        show(2, 7'h6D, 1'b0, 1);
        check("d2_capture", 16'(digits[11:8]), 16'h5);
        show(0, 7'h00, 1'b0, 1);

        // Overlapping enables, then D1 alone
        bads_seen = 0;
        show(5, 7'h7F, 1'b0, 10);
        check("d1_overlap", 16'(digits[15:12]), 16'h0);
        show(1, 7'h7F, 1'b0, 6);
        check("d1_eight", 16'(digits[15:12]), 16'h8);
        check("no_bad", 16'(bads_seen), 16'h0);
        show(0, 7'h00, 1'b0, 1);

        // Undecodable pattern on D3, frame still completes
        frames_seen = 0;
        bads_seen = 0;
        show(3, 7'h01, 1'b1, 6); show(0, 7'h00, 1'b0, 1);
        show(4, 7'h07, 1'b0, 6); show(0, 7'h00, 1'b0, 1);
        check("d3_bad", 16'(digits[7:4]), 16'hE);
        check("bad_once", 16'(bads_seen), 16'd1);
        check("frame_bad", 16'(frames_seen), 16'd1);
        check("dots_bad", 16'(dot_mask), 16'h2);

        // Randomized scan traffic
        for (int k = 0; k < 120; k++) begin
            logic [6:0] lit;
            int dig;
            dig = int'($urandom_range(0, 9));
            if (dig > 5) dig = dig - 5;
            if ($urandom_range(0, 5) == 0) lit = 7'($urandom);
            else lit = rpats[$urandom_range(0, 13)];
            show(dig, lit, 1'($urandom), int'($urandom_range(1, 8)));
        end

        // Stall timer
        show(3, 7'h06, 1'b0, 1);
        show(4, 7'h06, 1'b0, STALL - 1);
        check("stall_pre", 16'(stall), 16'h0);
        show(4, 7'h06, 1'b0, 1);
        check("stall_set", 16'(stall), 16'h1);
        show(0, 7'h00, 1'b0, 3);
        show(4, 7'h06, 1'b0, 10);
        check("stall_sat", 16'(stall), 16'h1);
        show(1, 7'h06, 1'b0, 1);
        check("stall_clr", 16'(stall), 16'h0);

        // Reset in the middle of a settle
        show(2, 7'h5B, 1'b1, 2);
        rst_b = 1'b0;
        tick();
        check("mid_rst_digits", digits, 16'hFFFF);
        check("mid_rst_dots", 16'(dot_mask), 16'h0);
        check("mid_rst_valid", 16'(valid), 16'h0);
        check("mid_rst_stall", 16'(stall), 16'h0);
        rst_b = 1'b1;
        show(0, 7'h00, 1'b0, 1);
        scan(7'h6D, 7'h7D, 7'h07, 7'h6F, 5);
        check("digits_5679", digits, 16'h5679);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
